// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan engine: hex font,
// PWM phase count and scan tick divider computation.
package seven_seg_pkg;

    localparam int unsigned PHASES = 16;

    // Active-high segments in gfedcba order.
    function automatic logic [6:0] hex_font(input logic [3:0] nibble);
        logic [6:0] seg;
        unique case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned digits,
                                             input int unsigned refresh_hz);
        int unsigned d;
        d = clk_hz / (digits * refresh_hz * PHASES);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/seven_seg_tick_gen.sv
// Enable-gated divider: emits a one-cycle tick every DIV enabled cycles.
module seven_seg_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan_engine.sv
// Multiplexed seven-segment driver with double-buffered data, PWM brightness,
// masking and blinking. Blink logic is present only when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scan_engine
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100000000,
    parameter int unsigned DIGIT_COUNT      = 8,
    parameter int unsigned REFRESH_HZ       = 200,
    parameter int unsigned BLINK_FRAMES     = 64,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_en,
    input  logic                     in_load,
    input  logic [DIGIT_COUNT*4-1:0] in_value,
    input  logic [DIGIT_COUNT-1:0]   in_dp,
    input  logic [DIGIT_COUNT-1:0]   in_mask,
    input  logic [DIGIT_COUNT-1:0]   in_blink,
    input  logic [3:0]               in_bright,
    output logic [DIGIT_COUNT-1:0]   out_anodes,
    output logic [7:0]               out_seg,
    output logic                     out_pending,
    output logic                     out_frame
);

    localparam int unsigned DIV = calc_div(CLK_HZ, DIGIT_COUNT, REFRESH_HZ);
    localparam int unsigned DW  = $clog2(DIGIT_COUNT);
    localparam logic [DIGIT_COUNT-1:0] AN_OFF  = {DIGIT_COUNT{ANODE_ACTIVE_LOW}};
    localparam logic [7:0]             SEG_OFF = {8{SEG_ACTIVE_LOW}};

    typedef struct packed {
        logic [DIGIT_COUNT*4-1:0] value;
        logic [DIGIT_COUNT-1:0]   dp;
        logic [DIGIT_COUNT-1:0]   mask;
        logic [DIGIT_COUNT-1:0]   blink;
    } buf_t;

    localparam buf_t BUF_RST = '{value: '0, dp: '0, mask: '1, blink: '0};

    logic          tick, boundary, blink_state, dark;
    logic [3:0]    phase_q, phase_d;
    logic [DW-1:0] digit_q, digit_d;
    logic          pwm_on_q, pwm_on_d;
    logic          pend_q, pend_d;
    buf_t          active_q, active_d, pending_q, pending_d, in_buf;
    logic [DIGIT_COUNT-1:0] anodes_on;
    logic [7:0]             seg_on;

    seven_seg_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (in_clk),
        .rst  (in_rst),
        .en   (in_en),
        .tick (tick)
    );

    assign in_buf = '{value: in_value, dp: in_dp, mask: in_mask, blink: in_blink};

    // PWM decision is latched per phase so a brightness change never glitches mid-phase.
    always_comb begin
        phase_d  = phase_q;
        digit_d  = digit_q;
        pwm_on_d = pwm_on_q;
        boundary = 1'b0;
        if (tick) begin
            phase_d  = phase_q + 4'd1;
            pwm_on_d = (phase_d <= in_bright);
            if (phase_q == 4'(PHASES - 1)) begin
                if (digit_q == DW'(DIGIT_COUNT - 1)) begin
                    digit_d  = '0;
                    boundary = 1'b1;
                end else begin
                    digit_d = digit_q + DW'(1);
                end
            end
        end
    end

    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (boundary) begin
            pend_d = 1'b0;
            if (in_load) begin
                active_d = in_buf;
            end else if (pend_q) begin
                active_d = pending_q;
            end
        end else if (in_load) begin
            pending_d = in_buf;
            pend_d    = 1'b1;
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int unsigned BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCW-1:0] blink_cnt_q;
    logic           blink_q, blink_wrap;

    assign blink_wrap  = boundary && (blink_cnt_q == BCW'(BLINK_FRAMES - 1));
    assign blink_state = blink_wrap ? ~blink_q : blink_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (boundary) begin
            blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BCW'(1);
            blink_q     <= blink_state;
        end
    end
`else
    assign blink_state = 1'b0;
`endif

    // Outputs are built from next-state so they line up with the frame pulse.
    always_comb begin
        dark = !pwm_on_d || active_d.mask[digit_d] ||
               (active_d.blink[digit_d] && blink_state) || !in_en;
        anodes_on = '0;
        seg_on    = '0;
        if (!dark) begin
            anodes_on = DIGIT_COUNT'(1) << digit_d;
            seg_on    = {active_d.dp[digit_d], hex_font(active_d.value[{digit_d, 2'b00} +: 4])};
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            phase_q    <= '0;
            digit_q    <= '0;
            pwm_on_q   <= 1'b1;
            active_q   <= BUF_RST;
            pending_q  <= BUF_RST;
            pend_q     <= 1'b0;
            out_anodes <= AN_OFF;
            out_seg    <= SEG_OFF;
            out_frame  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            digit_q    <= digit_d;
            pwm_on_q   <= pwm_on_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_q     <= pend_d;
            out_anodes <= anodes_on ^ AN_OFF;
            out_seg    <= seg_on ^ SEG_OFF;
            out_frame  <= boundary;
        end
    end

    assign out_pending = pend_q;

endmodule

// File: tb/tb_seven_seg_scan_engine.sv
// Self-checking bench for seven_seg_scan_engine: directed steps plus random traffic
// against a frame/tick-count reference model.
module tb_seven_seg_scan_engine;

    localparam int D           = 4;
    localparam int DIV         = 2;
    localparam int FRAME_TICKS = 16 * D;
    localparam int FRAME_CYC   = FRAME_TICKS * DIV;
    localparam int BF          = 2;

    logic        in_clk = 1'b0;
    logic        in_rst, in_en, in_load;
    logic [15:0] in_value;
    logic [3:0]  in_dp, in_mask, in_blink, in_bright;
    logic [3:0]  out_anodes;
    logic [7:0]  out_seg;
    logic        out_pending, out_frame;

    seven_seg_scan_engine #(
        .CLK_HZ           (3200),
        .DIGIT_COUNT      (D),
        .REFRESH_HZ       (25),
        .BLINK_FRAMES     (BF),
        .ANODE_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b1)
    ) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_en       (in_en),
        .in_load     (in_load),
        .in_value    (in_value),
        .in_dp       (in_dp),
        .in_mask     (in_mask),
        .in_blink    (in_blink),
        .in_bright   (in_bright),
        .out_anodes  (out_anodes),
        .out_seg     (out_seg),
        .out_pending (out_pending),
        .out_frame   (out_frame)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position derived from the count of enabled cycles and ticks.
    logic [6:0] font_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          en_cycles, ticks;
    bit          m_lit, m_pflag, m_frame;
    logic [15:0] a_val, p_val;
    logic [3:0]  a_dp, a_mask, a_blink, p_dp, p_mask, p_blink;

    int         an_cnt [4];
    logic [7:0] seg_seen [4];
    int         pulses, start_frame;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        en_cycles = 0;
        ticks     = 0;
        m_lit     = 1'b1;
        m_pflag   = 1'b0;
        m_frame   = 1'b0;
        a_val = '0; a_dp = '0; a_mask = 4'hF; a_blink = '0;
        p_val = '0; p_dp = '0; p_mask = 4'hF; p_blink = '0;
    endfunction

    function automatic bit next_is_boundary();
        return in_en && (en_cycles % DIV == DIV - 1) && ((ticks + 1) % FRAME_TICKS == 0);
    endfunction

    function automatic void model_edge();
        bit tk, bnd;
        tk  = in_en && (en_cycles % DIV == DIV - 1);
        bnd = tk && ((ticks + 1) % FRAME_TICKS == 0);
        if (in_en) en_cycles++;
        if (tk) begin
            ticks++;
            m_lit = (ticks % 16) <= int'(in_bright);
        end
        if (bnd) begin
            if (in_load) begin
                a_val = in_value; a_dp = in_dp; a_mask = in_mask; a_blink = in_blink;
            end else if (m_pflag) begin
                a_val = p_val; a_dp = p_dp; a_mask = p_mask; a_blink = p_blink;
            end
            m_pflag = 1'b0;
        end else if (in_load) begin
            p_val = in_value; p_dp = in_dp; p_mask = in_mask; p_blink = in_blink;
            m_pflag = 1'b1;
        end
        m_frame = bnd;
    endfunction

    task automatic check_outputs();
        int   dig;
        bit   bst, dark;
        logic [3:0] ea;
        logic [7:0] es;
        dig = (ticks / 16) % D;
`ifdef SEVEN_SEG_BLINK_EN
        bst = ((ticks / FRAME_TICKS) / BF) % 2 == 1;
`else
        bst = 1'b0;
`endif
        dark = !m_lit || a_mask[dig] || (a_blink[dig] && bst) || !in_en;
        ea = dark ? 4'hF : ~(4'b0001 << dig);
        es = dark ? 8'hFF : ~{a_dp[dig], font_tbl[a_val[dig*4 +: 4]]};
        chk("outputs", {20'd0, out_anodes, out_seg, out_pending, out_frame},
            {20'd0, ea, es, m_pflag, m_frame});
    endtask

    task automatic step();
        @(posedge in_clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] mask,
                        input logic [3:0] blink);
        in_value = v; in_dp = dp; in_mask = mask; in_blink = blink;
        in_load = 1'b1;
        step();
        in_load = 1'b0;
    endtask

    task automatic align_frame();
        int n = 0;
        while (out_frame !== 1'b1 && n < 3 * FRAME_CYC) begin
            step();
            n++;
        end
        chk("frame_seen", {31'd0, out_frame}, 32'd1);
    endtask

    task automatic count_frame();
        align_frame();
        start_frame = ticks / FRAME_TICKS;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            an_cnt[i]   = 0;
            seg_seen[i] = 8'hFF;
        end
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (out_frame === 1'b1) pulses++;
            for (int i = 0; i < 4; i++) begin
                if (out_anodes[i] === 1'b0) begin
                    an_cnt[i]++;
                    seg_seen[i] = out_seg;
                end
            end
            if (c < FRAME_CYC - 1) step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        in_rst = 1'b1; in_en = 1'b0; in_load = 1'b0;
        in_value = '0; in_dp = '0; in_mask = '0; in_blink = '0; in_bright = 4'd15;
        repeat (2) @(posedge in_clk);
        #1;
        chk("reset_anodes", {28'd0, out_anodes}, 32'hF);
        chk("reset_seg", {24'd0, out_seg}, 32'hFF);
        chk("reset_pend_frame", {30'd0, out_pending, out_frame}, 32'd0);
        in_rst = 1'b0;
        model_reset();
        in_en = 1'b1;
        repeat (10) step();

        // Scan and font.
        load(16'h3A07, 4'b0100, 4'b0000, 4'b0000);
        count_frame();
        for (int i = 0; i < 4; i++) chk($sformatf("scan_cnt%0d", i), an_cnt[i], 32);
        chk("font_d0", {24'd0, seg_seen[0]}, 32'hF8);
        chk("font_d1", {24'd0, seg_seen[1]}, 32'hC0);
        chk("font_d2", {24'd0, seg_seen[2]}, 32'h08);
        chk("font_d3", {24'd0, seg_seen[3]}, 32'hB0);

        // Brightness.
        in_bright = 4'd3;
        count_frame();
        for (int i = 0; i < 4; i++) chk($sformatf("bright3_cnt%0d", i), an_cnt[i], 8);
        in_bright = 4'd0;
        count_frame();
        for (int i = 0; i < 4; i++) chk($sformatf("bright0_cnt%0d", i), an_cnt[i], 2);
        in_bright = 4'd15;

        // Double buffer: last write before the boundary wins.
        align_frame();
        repeat (20) step();
        load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
        chk("dbuf_pending_set", {31'd0, out_pending}, 32'd1);
        repeat (30) step();
        load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
        align_frame();
        chk("dbuf_pending_clr", {31'd0, out_pending}, 32'd0);
        chk("dbuf_anodes", {28'd0, out_anodes}, 32'hE);
        chk("dbuf_seg", {24'd0, out_seg}, 32'hA4);
        count_frame();
        chk("dbuf_pulses", pulses, 1);

        // Load on the boundary tick bypasses pending; mask hides digit 1.
        begin
            int n = 0;
            while (!next_is_boundary() && n < 2 * FRAME_CYC) begin
                step();
                n++;
            end
        end
        load(16'($urandom), 4'($urandom), 4'b0010, 4'b0000);
        chk("bypass_pending", {31'd0, out_pending}, 32'd0);
        chk("bypass_frame", {31'd0, out_frame}, 32'd1);
        count_frame();
        chk("mask_cnt1", an_cnt[1], 0);
        chk("mask_cnt0", an_cnt[0], 32);

        // Blink on digit 0.
        load(16'h8888, 4'b0000, 4'b0000, 4'b0001);
        for (int f = 0; f < 5; f++) begin
            count_frame();
`ifdef SEVEN_SEG_BLINK_EN
            chk($sformatf("blink_f%0d", start_frame), an_cnt[0],
                ((start_frame / BF) % 2 == 1) ? 0 : 32);
`else
            chk($sformatf("blink_f%0d", start_frame), an_cnt[0], 32);
`endif
            chk("blink_d3", an_cnt[3], 32);
        end

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            in_en   = ($urandom % 8) != 0;
            in_load = ($urandom % 40) == 0;
            if (in_load) begin
                in_value = 16'($urandom);
                in_dp    = 4'($urandom);
                in_mask  = 4'($urandom) & 4'($urandom);
                in_blink = 4'($urandom);
            end
            if ($urandom % 50 == 0) in_bright = 4'($urandom);
            step();
        end
        in_load = 1'b0;
        in_en   = 1'b1;

        // Asynchronous reset mid-scan with pending data.
        load(16'h4321, 4'b1111, 4'b0000, 4'b0000);
        #2;
        in_rst = 1'b1;
        #1;
        chk("async_rst_anodes", {28'd0, out_anodes}, 32'hF);
        chk("async_rst_seg", {24'd0, out_seg}, 32'hFF);
        chk("async_rst_pending", {31'd0, out_pending}, 32'd0);
        @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        model_reset();
        repeat (FRAME_CYC + 10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
